// File: rtl/jtag_tap_controller_pkg.sv
// Shared JTAG/DTM types: TAP state encoding, DTM instruction codes and the TAP next-state function.
package debug_cfg_types;

    localparam int DMI_WIDTH     = 41;
    localparam int JTAG_IR_WIDTH = 5;

    localparam logic [JTAG_IR_WIDTH-1:0] JTAG_IR_IDCODE = 5'h01;
    localparam logic [JTAG_IR_WIDTH-1:0] JTAG_IR_DTMCS  = 5'h10;
    localparam logic [JTAG_IR_WIDTH-1:0] JTAG_IR_DMI    = 5'h11;
    localparam logic [JTAG_IR_WIDTH-1:0] JTAG_IR_BYPASS = 5'h1F;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } jtag_state_t;

    function automatic jtag_state_t jtag_next_state(input jtag_state_t s, input logic tms);
        jtag_state_t n;
        unique case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_DR:        n = tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
            SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_controller_pin_sync.sv
// Equal-depth synchronizers for tck/tms/tdi plus tck edge detect in the clk domain.
// Edges appear SYNC_STAGES clk after the pin changes; rise and fall are mutually exclusive.
module jtag_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tms_o,
    output logic tdi_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q;
    logic                   tck_prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tck_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_q      <= (tck_q << 1) | SYNC_STAGES'(tck_i);
            tms_q      <= (tms_q << 1) | SYNC_STAGES'(tms_i);
            tdi_q      <= (tdi_q << 1) | SYNC_STAGES'(tdi_i);
            tck_prev_q <= tck_q[SYNC_STAGES-1];
        end
    end

    assign tms_o      = tms_q[SYNC_STAGES-1];
    assign tdi_o      = tdi_q[SYNC_STAGES-1];
    assign tck_rise_o =  tck_q[SYNC_STAGES-1] & ~tck_prev_q;
    assign tck_fall_o = ~tck_q[SYNC_STAGES-1] &  tck_prev_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// Oversampled TAP FSM with IDCODE/DTMCS/DMI/BYPASS registers feeding the DTM.
// State and shift registers move one clk after a detected tck edge; update pulses last one clk.
module jtag_tap_controller
    import debug_cfg_types::*;
#(
    parameter logic [31:0] IDCODE      = 32'h0000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tck,
    input  logic                 tms,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [31:0]          current_dtmcs,
    output logic [31:0]          updated_dtmcs,
    output logic                 update_dtmcs,
    input  logic [DMI_WIDTH-1:0] current_dmi,
    output logic [DMI_WIDTH-1:0] updated_dmi,
    output logic                 update_dmi,
    output logic                 dtm_reset
);

    logic tms_s, tdi_s, tck_rise, tck_fall;

    jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .tck_i      (tck),
        .tms_i      (tms),
        .tdi_i      (tdi),
        .tms_o      (tms_s),
        .tdi_o      (tdi_s),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall)
    );

    jtag_state_t              state_q, state_d;
    logic [JTAG_IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DMI_WIDTH-1:0]     dr_sr_q, dr_sr_d;
    logic [31:0]              updated_dtmcs_q, updated_dtmcs_d;
    logic [DMI_WIDTH-1:0]     updated_dmi_q, updated_dmi_d;
    logic                     upd_dtmcs_q, upd_dtmcs_d, upd_dmi_q, upd_dmi_d;
    logic                     tdo_q, tdo_d, dtm_reset_q, dtm_reset_d;

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        ir_sr_d         = ir_sr_q;
        dr_sr_d         = dr_sr_q;
        updated_dtmcs_d = updated_dtmcs_q;
        updated_dmi_d   = updated_dmi_q;
        upd_dtmcs_d     = 1'b0;
        upd_dmi_d       = 1'b0;
        tdo_d           = tdo_q;

        if (tck_rise) begin
            state_d = jtag_next_state(state_q, tms_s);
            case (state_q)
                CAPTURE_IR: ir_sr_d = 5'b00001;
                SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[JTAG_IR_WIDTH-1:1]};
                CAPTURE_DR: begin
                    case (ir_q)
                        JTAG_IR_IDCODE: dr_sr_d = DMI_WIDTH'(IDCODE);
                        JTAG_IR_DTMCS:  dr_sr_d = DMI_WIDTH'(current_dtmcs);
                        JTAG_IR_DMI:    dr_sr_d = current_dmi;
                        default:        dr_sr_d = '0;
                    endcase
                end
                SHIFT_DR: begin
                    // tdi enters at the top of the active length; bits above it are don't-care
                    dr_sr_d = dr_sr_q >> 1;
                    case (ir_q)
                        JTAG_IR_DMI:                   dr_sr_d[DMI_WIDTH-1] = tdi_s;
                        JTAG_IR_IDCODE, JTAG_IR_DTMCS: dr_sr_d[31]          = tdi_s;
                        default:                       dr_sr_d[0]           = tdi_s;
                    endcase
                end
                default: ;
            endcase

            if (state_d == UPDATE_IR) ir_d = ir_sr_q;
            if (state_d == TEST_LOGIC_RESET) ir_d = JTAG_IR_IDCODE;
            if (state_d == UPDATE_DR) begin
                case (ir_q)
                    JTAG_IR_DTMCS: begin
                        updated_dtmcs_d = dr_sr_q[31:0];
                        upd_dtmcs_d     = 1'b1;
                    end
                    JTAG_IR_DMI: begin
                        updated_dmi_d = dr_sr_q;
                        upd_dmi_d     = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        if (tck_fall) begin
            if (state_q == SHIFT_DR)      tdo_d = dr_sr_q[0];
            else if (state_q == SHIFT_IR) tdo_d = ir_sr_q[0];
            else                          tdo_d = 1'b0;
        end

        dtm_reset_d = (state_d == TEST_LOGIC_RESET);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= TEST_LOGIC_RESET;
            ir_q            <= JTAG_IR_IDCODE;
            ir_sr_q         <= '0;
            dr_sr_q         <= '0;
            updated_dtmcs_q <= '0;
            updated_dmi_q   <= '0;
            upd_dtmcs_q     <= 1'b0;
            upd_dmi_q       <= 1'b0;
            tdo_q           <= 1'b0;
            dtm_reset_q     <= 1'b1;
        end else begin
            state_q         <= state_d;
            ir_q            <= ir_d;
            ir_sr_q         <= ir_sr_d;
            dr_sr_q         <= dr_sr_d;
            updated_dtmcs_q <= updated_dtmcs_d;
            updated_dmi_q   <= updated_dmi_d;
            upd_dtmcs_q     <= upd_dtmcs_d;
            upd_dmi_q       <= upd_dmi_d;
            tdo_q           <= tdo_d;
            dtm_reset_q     <= dtm_reset_d;
        end
    end

    assign tdo           = tdo_q;
    assign updated_dtmcs = updated_dtmcs_q;
    assign update_dtmcs  = upd_dtmcs_q;
    assign updated_dmi   = updated_dmi_q;
    assign update_dmi    = upd_dmi_q;
    assign dtm_reset     = dtm_reset_q;

endmodule

// File: doc/jtag_tap_controller.md
# jtag_tap_controller

Oversampled IEEE 1149.1 TAP controller and RISC-V DTM register shifter. It sits directly upstream of the DTM DMI/DTMCS logic. It samples the JTAG pins in the `clk` domain, runs the 16-state TAP FSM, and captures/shifts the IDCODE, DTMCS, DMI and BYPASS data registers. On Update-DR it presents the shifted DTMCS/DMI value to the downstream logic with a one-cycle update pulse.

## Interface
Parameters:
- `IDCODE`, default 32'h0000_0001, value captured by the IDCODE instruction; bit 0 must be 1.
- `SYNC_STAGES`, default 2, synchronizer depth on `tck`/`tms`/`tdi`.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `tck`, `tms`, `tdi` in 1 each: asynchronous JTAG pins.
- `tdo` out 1: registered serial output.
- `current_dtmcs` in 32: DTMCS value loaded at Capture-DR.
- `updated_dtmcs` out 32: last DTMCS value shifted in.
- `update_dtmcs` out 1: one-cycle pulse on DTMCS Update-DR.
- `current_dmi` in 41: {address[6:0], data[31:0], op[1:0]} loaded at Capture-DR.
- `updated_dmi` out 41: last DMI value shifted in.
- `update_dmi` out 1: one-cycle pulse on DMI Update-DR.
- `dtm_reset` out 1: high while the FSM is in TEST_LOGIC_RESET or `reset_n`=0; drives the downstream `reset`.

## Operation
- **Pin sampling**
  - `tck`, `tms` and `tdi` each pass through `SYNC_STAGES` flops, so all three have equal delay.
  - tck_rise = sync high and previous sync low; tck_fall is the inverse. Both are never asserted in the same cycle.
- **FSM** advances only on tck_rise, using the synced tms. States and transitions (tms=0 / tms=1):
  - TEST_LOGIC_RESET → RUN_TEST_IDLE / TEST_LOGIC_RESET.
  - RUN_TEST_IDLE → RUN_TEST_IDLE / SELECT_DR.
  - SELECT_DR → CAPTURE_DR / SELECT_IR.
  - SELECT_IR → CAPTURE_IR / TEST_LOGIC_RESET.
  - CAPTURE_x → SHIFT_x / EXIT1_x.
  - SHIFT_x → SHIFT_x / EXIT1_x.
  - EXIT1_x → PAUSE_x / UPDATE_x.
  - PAUSE_x → PAUSE_x / EXIT2_x.
  - EXIT2_x → SHIFT_x / UPDATE_x.
  - UPDATE_x → RUN_TEST_IDLE / SELECT_DR.
- **IR** is 5 bits.
  - Instructions: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI, 0x1F BYPASS; any other code selects BYPASS.
  - CAPTURE_IR loads 5'b00001 into the shift register.
  - IR takes the shifted value in UPDATE_IR.
  - Entering TEST_LOGIC_RESET sets IR=0x01.
- **DR shift register** is 41 bits; the active length is 32 (IDCODE, DTMCS), 41 (DMI) or 1 (BYPASS).
  - Capture loads `IDCODE`, `current_dtmcs`, `current_dmi`, or 0 respectively.
  - Shift moves right: synced `tdi` enters bit length-1 and bit 0 leaves. Bits above the active length are don't-care.
- **Update-DR**
  - IR=DTMCS: `updated_dtmcs`←sr[31:0] and `update_dtmcs` pulses.
  - IR=DMI: `updated_dmi`←sr[40:0] and `update_dmi` pulses.
  - IDCODE/BYPASS: no pulse.
  - `updated_*` hold their value until the next update.
- **`tdo`** is loaded with sr[0] (or IR sr[0]) on tck_fall while in SHIFT_DR/SHIFT_IR; otherwise it is loaded with 0. There is no tristate.

## Timing
- Reset (`reset_n`=0 for one `clk`): state TEST_LOGIC_RESET, IR=0x01, shift registers 0, sync flops 0, `tdo`=0, `update_*`=0, `updated_*`=0, `dtm_reset`=1.
- Reset mid-shift aborts the operation with no update pulse.
- `tck` high and low phases must each be ≥ SYNC_STAGES+1 `clk` periods; shorter pulses are undefined.
- Latency:
  - State/shift register change: the `clk` after tck_rise is detected.
  - The shift-register LSB is presented on `tdo` at the first tck_fall after the Capture/Shift transition. Data is therefore stable for the next tck_rise.
  - `update_*` is high for exactly one `clk`, the cycle after the FSM enters UPDATE_DR. It never repeats while the FSM stays in UPDATE_DR.
- Five tck_rise edges with tms=1 reach TEST_LOGIC_RESET from any state.
- `dtm_reset` rises in the `clk` after entry and falls the `clk` after the FSM leaves TEST_LOGIC_RESET.

## Structure
- `debug_cfg_types` package gains:
  - `jtag_state_t`, a 16-value enum.
  - IR constants `JTAG_IR_IDCODE`, `JTAG_IR_DTMCS`, `JTAG_IR_DMI`, `JTAG_IR_BYPASS`.
  - `DMI_WIDTH`=41.
- Sub-module `jtag_pin_sync` holds the synchronizer chains plus tck rise/fall detection.

## Test plan
- Reset, then tms sequence 0,1,0,0 to SHIFT_DR, then 32 shifts → `tdo` streams `IDCODE` LSB first (default: 1 then 31 zeros).
- Select IR=0x10, drive `current_dtmcs`=32'h0000_5071, capture and shift 32'h0001_0000, Update-DR → `tdo` streamed 0x5071 LSB first; `update_dtmcs` high for 1 `clk`; `updated_dtmcs`=32'h0001_0000.
- IR=0x11, shift {7'h10, 32'h1, 2'b10}, Update-DR → `updated_dmi`=41'h40_0000_0006; `update_dmi` high for one cycle; no `update_dtmcs`.
- IR=0x05 (unknown), shift 8'hA5 → `tdo` shows 0 then tdi delayed by one bit; no update pulses.
- From SHIFT_IR, 5 tck with tms=1 → TEST_LOGIC_RESET, `dtm_reset`=1, IR=0x01; next DR scan returns `IDCODE`.
- `reset_n` low mid SHIFT_DR of DMI → `tdo`=0, no `update_dmi`, `updated_dmi`=0, `dtm_reset`=1.
